imm_decode_stage: RTL and testbench

Parametrised, registered immediate-decode stage for the RISC-V core. It replaces the purely combinational immediate generator in the decode path. It accepts an instruction word plus PC through a valid/ready handshake and extracts the sign- or zero-extended immediate at XLEN width. It also classifies the immediate format and precomputes the PC-relative target (PC + imm), then buffers results in a 2-entry skid queue so execute-stage stalls do not combinationally back-propagate into fetch.

---
 rtl/imm_decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode_stage
//  Purpose  : Registered RISC-V immediate decoder. Accepts an instruction word
//             and its PC over valid/ready, decodes the immediate format,
//             sign/zero-extends the immediate to XLEN, precomputes PC + imm,
//             and holds results in a small circular skid queue so that
//             downstream stalls never reach in_ready combinationally.
//  Params   : XLEN  - datapath width (32 or 64); at 64 OP-IMM-32 is I-type
//             DEPTH - skid-queue entries (1 or 2)
//  Ports    : clk, rst (sync, active-high), flush (sync kill of queue)
//             in_valid/in_ready/in_ir/in_pc           - upstream handshake
//             out_valid/out_ready/out_imm/out_type/
//             out_target/out_pc/out_illegal           - head entry
//  Macro    : ZICSR_ZIMM_EN - SYSTEM words with ir[14]=1 decode as type Z
//             (imm = zext(ir[19:15])); undefined -> all SYSTEM words NONE
//  Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    // Pointers are at least one bit wide; storage is rounded up to a power
    // of two so every pointer value indexes a real slot.
    localparam int              c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam int              c_SLOTS = 1 << c_PW;
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);

    localparam logic [2:0] c_TYPE_NONE = 3'd0;
    localparam logic [2:0] c_TYPE_I    = 3'd1;
    localparam logic [2:0] c_TYPE_S    = 3'd2;
    localparam logic [2:0] c_TYPE_B    = 3'd3;
    localparam logic [2:0] c_TYPE_U    = 3'd4;
    localparam logic [2:0] c_TYPE_J    = 3'd5;
`ifdef ZICSR_ZIMM_EN
    localparam logic [2:0] c_TYPE_Z    = 3'd6;
`endif

    localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] c_OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] c_OP_STORE   = 7'b0100011;
    localparam logic [6:0] c_OP_OP      = 7'b0110011;
    localparam logic [6:0] c_OP_LUI     = 7'b0110111;
    localparam logic [6:0] c_OP_OP32    = 7'b0111011;
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OP_JALR    = 7'b1100111;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM  = 7'b1110011;

    // ------------------------------------------------------------------
    // Push-time decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_imm     = '0;
        w_type    = c_TYPE_NONE;
        w_illegal = 1'b0;
        case (in_ir[6:0])
            c_OP_LOAD, c_OP_OPIMM, c_OP_JALR: begin
                w_type = c_TYPE_I;
                w_imm  = {{(XLEN-11){in_ir[31]}}, in_ir[30:20]};
            end
            c_OP_OPIMM32: begin
                if (XLEN == 64) begin
                    w_type = c_TYPE_I;
                    w_imm  = {{(XLEN-11){in_ir[31]}}, in_ir[30:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_STORE: begin
                w_type = c_TYPE_S;
                w_imm  = {{(XLEN-11){in_ir[31]}}, in_ir[30:25], in_ir[11:7]};
            end
            c_OP_BRANCH: begin
                w_type = c_TYPE_B;
                w_imm  = {{(XLEN-12){in_ir[31]}}, in_ir[7], in_ir[30:25],
                          in_ir[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                // Bit 31 doubles as the sign for the upper XLEN-32 bits.
                w_type = c_TYPE_U;
                w_imm  = {{(XLEN-31){in_ir[31]}}, in_ir[30:12], 12'b0};
            end
            c_OP_JAL: begin
                w_type = c_TYPE_J;
                w_imm  = {{(XLEN-20){in_ir[31]}}, in_ir[19:12], in_ir[20],
                          in_ir[30:21], 1'b0};
            end
            c_OP_SYSTEM: begin
`ifdef ZICSR_ZIMM_EN
                if (in_ir[14]) begin
                    w_type = c_TYPE_Z;
                    w_imm  = {{(XLEN-5){1'b0}}, in_ir[19:15]};
                end
`endif
            end
            c_OP_OP, c_OP_OP32, c_OP_MISCMEM: begin
                w_type = c_TYPE_NONE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Target is computed for every entry, NONE included (pc + 0).
    assign w_target = in_pc + w_imm;

    // ------------------------------------------------------------------
    // Skid queue
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_imm    [c_SLOTS];
    logic [2:0]      r_type   [c_SLOTS];
    logic [XLEN-1:0] r_target [c_SLOTS];
    logic [XLEN-1:0] r_pc     [c_SLOTS];
    logic            r_ill    [c_SLOTS];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= f_next(r_tail);
            if (w_pop)  r_head <= f_next(r_head);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Payload needs no reset: it is only visible through out_valid gating.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_imm[r_tail]    <= w_imm;
            r_type[r_tail]   <= w_type;
            r_target[r_tail] <= w_target;
            r_pc[r_tail]     <= in_pc;
            r_ill[r_tail]    <= w_illegal;
        end
    end

    assign out_imm     = out_valid ? r_imm[r_head]    : '0;
    assign out_type    = out_valid ? r_type[r_head]   : 3'd0;
    assign out_target  = out_valid ? r_target[r_head] : '0;
    assign out_pc      = out_valid ? r_pc[r_head]     : '0;
    assign out_illegal = out_valid ? r_ill[r_head]    : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_decode_stage
//  Purpose  : Self-checking bench for imm_decode_stage. Drives a 32-bit,
//             depth-2 instance and a 64-bit, depth-1 instance with the same
//             stimulus and compares both against a queue-based reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  ty;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_ir;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_target, a_out_pc;
    logic [2:0]  a_out_type;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_target, b_out_pc;
    logic [2:0]  b_out_type;

    int checks   = 0;
    int failures = 0;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ir(in_ir), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_type(a_out_type), .out_target(a_out_target), .out_pc(a_out_pc),
        .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_type(b_out_type), .out_target(b_out_target), .out_pc(b_out_pc),
        .out_illegal(b_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: immediates as signed integers built from field
    // weights, then reduced modulo 2^XLEN.
    function automatic ent_t ref_dec(input logic [31:0] ir, input logic [63:0] pc, input bit is64);
        ent_t   e;
        longint v;
        logic [63:0] mask;
        v = 0; e.ty = 3'd0; e.ill = 1'b0;
        mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (ir[6:0])
            7'h03, 7'h13, 7'h67: begin e.ty = 1; v = longint'(ir[31:20]); if (ir[31]) v -= 4096; end
            7'h1B: if (is64) begin e.ty = 1; v = longint'(ir[31:20]); if (ir[31]) v -= 4096; end
                   else e.ill = 1'b1;
            7'h23: begin e.ty = 2; v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]); if (ir[31]) v -= 4096; end
            7'h63: begin
                e.ty = 3;
                v = longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
                if (ir[31]) v -= 4096;
            end
            7'h37, 7'h17: begin e.ty = 4; v = longint'(ir[31:12]) * 4096; if (ir[31]) v -= 64'sh1_0000_0000; end
            7'h6F: begin
                e.ty = 5;
                v = longint'(ir[19:12]) * 4096 + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
                if (ir[31]) v -= 1048576;
            end
            7'h33, 7'h3B, 7'h0F: e.ty = 0;
            7'h73: begin
`ifdef ZICSR_ZIMM_EN
                if (ir[14]) begin e.ty = 6; v = longint'(ir[19:15]); end
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v) & mask;
        e.pc  = pc & mask;
        e.tgt = (pc + 64'(v)) & mask;
        return e;
    endfunction

    // One clock: compare both DUTs to the model at the falling edge, drive
    // new inputs, then advance the model at the rising edge.
    task automatic cycle(input bit v, input logic [31:0] ir, input logic [63:0] pc,
                         input bit rdy, input bit fl, input bit rs);
        ent_t e;
        bit   pa, pb, ppa, ppb;
        @(negedge clk);
        e = '{default: '0};
        if (qa.size() != 0) e = qa[0];
        chk("a.out_valid", a_out_valid, qa.size() != 0);
        chk("a.in_ready", a_in_ready, qa.size() != 2);
        chk("a.out_imm", a_out_imm, e.imm);
        chk("a.out_type", a_out_type, e.ty);
        chk("a.out_target", a_out_target, e.tgt);
        chk("a.out_pc", a_out_pc, e.pc);
        chk("a.out_illegal", a_out_illegal, e.ill);
        e = '{default: '0};
        if (qb.size() != 0) e = qb[0];
        chk("b.out_valid", b_out_valid, qb.size() != 0);
        chk("b.in_ready", b_in_ready, qb.size() != 1);
        chk("b.out_imm", b_out_imm, e.imm);
        chk("b.out_type", b_out_type, e.ty);
        chk("b.out_target", b_out_target, e.tgt);
        chk("b.out_pc", b_out_pc, e.pc);
        chk("b.out_illegal", b_out_illegal, e.ill);
        in_valid = v; in_ir = ir; in_pc = pc; out_ready = rdy; flush = fl; rst = rs;
        @(posedge clk);
        pa  = v && qa.size() < 2 && !fl;
        pb  = v && qb.size() < 1 && !fl;
        ppa = rdy && qa.size() != 0;
        ppb = rdy && qb.size() != 0;
        if (rs || fl) begin
            qa.delete(); qb.delete();
        end else begin
            if (ppa) void'(qa.pop_front());
            if (ppb) void'(qb.pop_front());
            if (pa) qa.push_back(ref_dec(ir, pc, 1'b0));
            if (pb) qb.push_back(ref_dec(ir, pc, 1'b1));
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 32'h0, 64'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] ir, input logic [63:0] pc, input bit rdy);
        cycle(1'b1, ir, pc, rdy, 1'b0, 1'b0);
    endtask

    logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ir = '0; in_pc = '0;
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);   // reset state checked here

        // Directed decode examples with literal expectations.
        push(32'hFFF0_0093, 64'h100, 1'b1);
        #1;
        chk("addi.imm", a_out_imm, 32'hFFFF_FFFF);
        chk("addi.type", a_out_type, 3'd1);
        chk("addi.target", a_out_target, 32'h0000_00FF);
        chk("addi.illegal", a_out_illegal, 1'b0);
        idle(1'b1);
        push(32'hFE00_0EE3, 64'h100, 1'b1);
        #1;
        chk("beq.imm", a_out_imm, 32'hFFFF_FFFC);
        chk("beq.type", a_out_type, 3'd3);
        chk("beq.target", a_out_target, 32'h0000_00FC);
        idle(1'b1);
        push(32'h1234_52B7, 64'h200, 1'b1);
        #1;
        chk("lui.imm", a_out_imm, 32'h1234_5000);
        chk("lui.type", a_out_type, 3'd4);
        idle(1'b1);
        push(32'h8000_02B7, 64'h0, 1'b1);
        #1;
        chk("lui64.imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        idle(1'b1);
        push(32'h0000_007F, 64'h40, 1'b1);
        #1;
        chk("bad.illegal", a_out_illegal, 1'b1);
        chk("bad.imm", a_out_imm, 32'h0);
        chk("bad64.illegal", b_out_illegal, 1'b1);
        idle(1'b1);
        push(32'h3002_D073, 64'h80, 1'b1);
        #1;
`ifdef ZICSR_ZIMM_EN
        chk("csr.type", a_out_type, 3'd6);
        chk("csr.imm", a_out_imm, 32'd5);
`else
        chk("csr.type", a_out_type, 3'd0);
        chk("csr.imm", a_out_imm, 32'd0);
`endif
        chk("csr.illegal", a_out_illegal, 1'b0);
        idle(1'b1);
        push(32'hFFF0_001B, 64'h10, 1'b1);   // OP-IMM-32: I-type only at XLEN=64
        #1;
        chk("opimm32.a_illegal", a_out_illegal, 1'b1);
        chk("opimm32.b_type", b_out_type, 3'd1);
        chk("opimm32.b_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1'b1);

        // Backpressure: three pushes against a stalled consumer, then drain.
        push(32'h0010_0093, 64'h1000, 1'b0);
        push(32'h0020_0093, 64'h1004, 1'b0);
        push(32'h0030_0093, 64'h1008, 1'b0);
        push(32'h0030_0093, 64'h1008, 1'b1);
        push(32'h0040_0093, 64'h100C, 1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // Flush with two entries queued and a word offered the same cycle.
        push(32'h0050_0093, 64'h2000, 1'b0);
        push(32'h0060_0093, 64'h2004, 1'b0);
        cycle(1'b1, 32'h0070_0093, 64'h2008, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // Reset mid-stream with a word offered.
        push(32'h0080_0093, 64'h3000, 1'b0);
        push(32'h0090_0093, 64'h3004, 1'b0);
        cycle(1'b1, 32'h00A0_0093, 64'h3008, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom();
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 13)];
            cycle($urandom_range(0, 3) != 0, {r[31:7], op},
                  {32'($urandom()), 32'($urandom())},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 99) == 0);
        end
        idle(1'b1); idle(1'b1); idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
